// File: rtl/decoder_n_scan.sv
// decoder_n_scan: registered N-to-2^N one-hot decoder with a prescaled up/down scan sequencer,
// load path, output polarity select and wrap strobe.
module decoder_n_scan #(
   parameter int N          = 3,
   parameter int STEP_DIV   = 1,
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              Enable,
   input  logic [1:0]        Mode,
   input  logic [N-1:0]      A,
   input  logic              Load,
   output logic [(1<<N)-1:0] D,
   output logic [N-1:0]      Idx,
   output logic              Active,
   output logic              Wrap
);
   localparam int W = 1 << N;
   localparam int PW = STEP_DIV > 1 ? $clog2(STEP_DIV) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(STEP_DIV - 1);
   localparam logic [W-1:0] OFF = {W{ACTIVE_LOW}};
   logic [N-1:0]  idx_q, idx_d;
   logic [PW-1:0] pre_q, pre_d;
   logic [W-1:0]  d_q, d_d;
   logic [1:0]    mode_q;
   logic          en_q, act_q, wrap_q, wrap_d, fresh;
   // A fresh cycle (just enabled or mode changed) restarts the prescaler without stepping.
   always_comb begin
      fresh = !en_q || (Mode != mode_q);
      idx_d = idx_q;
      pre_d = '0;
      wrap_d = 1'b0;
      if (Enable) begin
         if (Mode == 2'b00 || Load) idx_d = A;
         else if (!fresh) begin
            if (Mode == 2'b11) pre_d = pre_q;
            else if (pre_q != PRE_LAST) pre_d = pre_q + 1'b1;
            else begin
               idx_d = Mode[0] ? idx_q + 1'b1 : idx_q - 1'b1;
               wrap_d = Mode[0] ? &idx_q : ~|idx_q;
            end
         end
      end
      d_d = Enable ? OFF ^ (W'(1) << idx_d) : OFF;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         idx_q <= '0;
         pre_q <= '0;
         d_q <= OFF;
         mode_q <= 2'b00;
         en_q <= 1'b0;
         act_q <= 1'b0;
         wrap_q <= 1'b0;
      end else begin
         idx_q <= idx_d;
         pre_q <= pre_d;
         d_q <= d_d;
         mode_q <= Mode;
         en_q <= Enable;
         act_q <= Enable;
         wrap_q <= wrap_d;
      end
   end
   assign D = d_q;
   assign Idx = idx_q;
   assign Active = act_q;
   assign Wrap = wrap_q;
endmodule

// File: tb/tb_decoder_n_scan.sv
// tb_decoder_n_scan: directed checks of the decoder across three parameter sets sharing one stimulus.
module tb_decoder_n_scan;
   logic clk = 1'b0, reset = 1'b1, Enable = 1'b0, Load = 1'b0;
   logic [1:0] Mode = 2'b00;
   logic [2:0] A = 3'd0;
   logic [7:0] d3, d1, dl;
   logic [2:0] i3, i1, il;
   logic a3, a1, al, w3, w1, wl;
   int errors = 0, checks = 0;
   always #5 clk = ~clk;
   decoder_n_scan #(.N(3), .STEP_DIV(3), .ACTIVE_LOW(1'b0)) u3 (.clk(clk), .reset(reset), .Enable(Enable),
      .Mode(Mode), .A(A), .Load(Load), .D(d3), .Idx(i3), .Active(a3), .Wrap(w3));
   decoder_n_scan #(.N(3), .STEP_DIV(1), .ACTIVE_LOW(1'b0)) u1 (.clk(clk), .reset(reset), .Enable(Enable),
      .Mode(Mode), .A(A), .Load(Load), .D(d1), .Idx(i1), .Active(a1), .Wrap(w1));
   decoder_n_scan #(.N(3), .STEP_DIV(3), .ACTIVE_LOW(1'b1)) ul (.clk(clk), .reset(reset), .Enable(Enable),
      .Mode(Mode), .A(A), .Load(Load), .D(dl), .Idx(il), .Active(al), .Wrap(wl));
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic test_reset;
      reset = 1'b1; Enable = 1'b0;
      tick();
      checks++; if ({d3, i3, a3, w3} !== 13'd0) begin errors++; $display("FAIL reset u3 D=%h Idx=%0d Act=%b Wrap=%b expected 00/0/0/0", d3, i3, a3, w3); end
      checks++; if (dl !== 8'hFF) begin errors++; $display("FAIL reset_low D=%h expected ff", dl); end
      checks++; if ({i1, a1, w1} !== 5'd0) begin errors++; $display("FAIL reset u1 Idx=%0d Act=%b Wrap=%b expected 0/0/0", i1, a1, w1); end
   endtask
   task automatic test_direct;
      logic [7:0] exp_d;
      reset = 1'b0; Enable = 1'b1; Mode = 2'b00;
      for (int a = 0; a < 8; a++) begin
         A = 3'(a);
         tick();
         exp_d = 8'd1 << a;
         checks++; if ({d3, i3, a3, w3} !== {exp_d, 3'(a), 1'b1, 1'b0}) begin errors++; $display("FAIL direct A=%0d D=%h Idx=%0d Act=%b Wrap=%b expected %h/%0d/1/0", a, d3, i3, a3, w3, exp_d, a); end
         checks++; if (dl !== ~exp_d) begin errors++; $display("FAIL direct_low A=%0d D=%h expected %h", a, dl, ~exp_d); end
      end
   endtask
   task automatic test_enable_low;
      Enable = 1'b0; A = 3'd5;
      tick();
      checks++; if ({d3, i3, a3, w3} !== {8'h00, 3'd7, 1'b0, 1'b0}) begin errors++; $display("FAIL en_low D=%h Idx=%0d Act=%b Wrap=%b expected 00/7/0/0", d3, i3, a3, w3); end
      checks++; if ({dl, al} !== {8'hFF, 1'b0}) begin errors++; $display("FAIL en_low_low D=%h Act=%b expected ff/0", dl, al); end
   endtask
   task automatic test_scan_up;
      logic [7:0] exp_d [6] = '{8'h40, 8'h40, 8'h80, 8'h80, 8'h80, 8'h01};
      Enable = 1'b1; Mode = 2'b01; Load = 1'b1; A = 3'd6;
      tick();
      checks++; if ({d3, i3, w3} !== {8'h40, 3'd6, 1'b0}) begin errors++; $display("FAIL up_load D=%h Idx=%0d Wrap=%b expected 40/6/0", d3, i3, w3); end
      Load = 1'b0;
      for (int k = 0; k < 6; k++) begin
         tick();
         checks++; if ({d3, w3} !== {exp_d[k], k == 5}) begin errors++; $display("FAIL up_step%0d D=%h Wrap=%b expected %h/%b", k, d3, w3, exp_d[k], k == 5); end
      end
      tick();
      checks++; if ({d3, w3} !== {8'h01, 1'b0}) begin errors++; $display("FAIL up_after_wrap D=%h Wrap=%b expected 01/0", d3, w3); end
   endtask
   task automatic test_scan_down;
      Mode = 2'b10; Load = 1'b1; A = 3'd0;
      tick();
      checks++; if ({i1, w1} !== {3'd0, 1'b0}) begin errors++; $display("FAIL down_load Idx=%0d Wrap=%b expected 0/0", i1, w1); end
      Load = 1'b0;
      tick();
      checks++; if ({d1, i1, w1} !== {8'h80, 3'd7, 1'b1}) begin errors++; $display("FAIL down_wrap D=%h Idx=%0d Wrap=%b expected 80/7/1", d1, i1, w1); end
      Load = 1'b1; A = 3'd2;
      tick();
      checks++; if ({d1, i1, w1} !== {8'h04, 3'd2, 1'b0}) begin errors++; $display("FAIL down_loadprio D=%h Idx=%0d Wrap=%b expected 04/2/0", d1, i1, w1); end
      Load = 1'b0;
      tick();
      checks++; if ({d1, i1, w1} !== {8'h02, 3'd1, 1'b0}) begin errors++; $display("FAIL down_next D=%h Idx=%0d Wrap=%b expected 02/1/0", d1, i1, w1); end
      Mode = 2'b01;
      tick();
      checks++; if ({i1, w1} !== {3'd1, 1'b0}) begin errors++; $display("FAIL modechg_nostep Idx=%0d Wrap=%b expected 1/0", i1, w1); end
      tick();
      checks++; if (i1 !== 3'd2) begin errors++; $display("FAIL modechg_resume Idx=%0d expected 2", i1); end
   endtask
   task automatic test_hold;
      Mode = 2'b01; Load = 1'b1; A = 3'd3;
      tick();
      Load = 1'b0;
      tick(); tick(); tick();
      checks++; if (i3 !== 3'd4) begin errors++; $display("FAIL hold_pre Idx=%0d expected 4", i3); end
      Mode = 2'b11;
      for (int k = 0; k < 10; k++) begin
         tick();
         checks++; if ({d3, i3, w3} !== {8'h10, 3'd4, 1'b0}) begin errors++; $display("FAIL hold%0d D=%h Idx=%0d Wrap=%b expected 10/4/0", k, d3, i3, w3); end
      end
      Mode = 2'b01;
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++; if (i3 !== (k == 3 ? 3'd5 : 3'd4)) begin errors++; $display("FAIL hold_resume%0d Idx=%0d expected %0d", k, i3, k == 3 ? 5 : 4); end
      end
   endtask
   task automatic test_reset_mid;
      reset = 1'b1;
      tick();
      checks++; if ({d3, i3, a3, w3} !== 13'd0) begin errors++; $display("FAIL midreset D=%h Idx=%0d Act=%b Wrap=%b expected 00/0/0/0", d3, i3, a3, w3); end
      reset = 1'b0;
      tick();
      checks++; if ({d3, i3, a3} !== {8'h01, 3'd0, 1'b1}) begin errors++; $display("FAIL post_reset D=%h Idx=%0d Act=%b expected 01/0/1", d3, i3, a3); end
      tick();
      checks++; if (d3 !== 8'h01) begin errors++; $display("FAIL post_reset2 D=%h expected 01", d3); end
   endtask
   task automatic test_enable_resume;
      Enable = 1'b0;
      tick();
      checks++; if ({d3, i3, a3} !== {8'h00, 3'd0, 1'b0}) begin errors++; $display("FAIL pause D=%h Idx=%0d Act=%b expected 00/0/0", d3, i3, a3); end
      Enable = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++; if ({d3, a3} !== {(k == 3 ? 8'h02 : 8'h01), 1'b1}) begin errors++; $display("FAIL resume%0d D=%h Act=%b expected %h/1", k, d3, a3, k == 3 ? 8'h02 : 8'h01); end
      end
   endtask
   initial begin
      test_reset();
      test_direct();
      test_enable_low();
      test_scan_up();
      test_scan_down();
      test_hold();
      test_reset_mid();
      test_enable_resume();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
